// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES inverse cipher, one inverse round per clock.
// Consumes a pre-expanded key schedule (same layout as the encryption core).
// Optional build macro AES_DEC_ZEROIZE_EN: clears the state on DONE->IDLE and
// blanks plaintext whenever out_valid is low.

module aes_decrypt_iter #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             ciphertext,
  input  logic [0:(NR+1)*128-1]    w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             plaintext,
  output logic                     busy
);

  // Key length and round count must describe the same AES variant.
  if (NR != NK + 6) begin : g_bad_cfg
    $error("aes_decrypt_iter: NR must equal NK + 6");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   rc;
  logic [127:0] st;
  logic [127:0] key_sel;
  logic [127:0] round_out;
  logic [127:0] last_out;

  // rc indexes the round key used on the coming edge; no pipeline stage on the key.
  assign key_sel = w[{rc, 7'd0} +: 128];

  inv_round      u_round (.in(st), .key(key_sel), .out(round_out));
  inv_last_round u_last  (.in(st), .key(key_sel), .out(last_out));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ROUND);

`ifdef AES_DEC_ZEROIZE_EN
  assign plaintext = out_valid ? st : 128'h0;
`else
  assign plaintext = st;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: DONE is reachable only from the rc==0 round.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = ROUND;
      ROUND:   if (rc == 4'd0)   state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Datapath: initial whitening on accept, then one inverse round per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= '0;
      rc <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st <= ciphertext ^ w[NR*128 +: 128];
          rc <= 4'(NR - 1);
        end
        ROUND: if (rc != 4'd0) begin
          st <= round_out;
          rc <= rc - 4'd1;
        end else begin
          st <= last_out;
        end
        DONE: begin
`ifdef AES_DEC_ZEROIZE_EN
          if (out_ready) st <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// Full inverse round: InvMixColumns(InvSubBytes(InvShiftRows(in)) ^ key).
module inv_round (
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out
);
  logic [127:0] ss, ark;

  aes_inv_shift_sub u_ss (.in(in), .out(ss));
  assign ark = ss ^ key;

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_inv_mix_col u_mix (.in(ark[127-32*c -: 32]), .out(out[127-32*c -: 32]));
  end
endmodule

// Final inverse round: no InvMixColumns.
module inv_last_round (
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out
);
  logic [127:0] ss;

  aes_inv_shift_sub u_ss (.in(in), .out(ss));
  assign out = ss ^ key;
endmodule

// InvShiftRows folded into the wiring, then 16 inverse S-boxes.
// Byte k sits at column k/4, row k%4; row r rotates right by r columns.
module aes_inv_shift_sub (
  input  logic [127:0] in,
  output logic [127:0] out
);
  logic [0:15][7:0] b_in, b_out;

  assign b_in = in;
  assign out  = b_out;

  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int C   = k / 4;
    localparam int R   = k % 4;
    localparam int SRC = ((C - R + 4) % 4) * 4 + R;
    aes_inv_sbox u_sbox (.in(b_in[SRC]), .out(b_out[k]));
  end
endmodule

// Inverse S-box computed as GF(2^8) inverse of the inverse affine transform,
// so there is no 256-entry table to transcribe.
module aes_inv_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8) (and maps 0 to 0): square-and-multiply over bits 1..7.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  logic [7:0] aff;

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  assign aff = {in[6:0], in[7]} ^ {in[4:0], in[7:5]} ^ {in[1:0], in[7:2]} ^ 8'h05;
  assign out = ginv(aff);
endmodule

// InvMixColumns on one 32-bit column (byte 0 in the MSBs).
module aes_inv_mix_col (
  input  logic [31:0] in,
  output logic [31:0] out
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e) via xtime chain.
  function automatic logic [7:0] gm(input logic [7:0] v, input logic [3:0] c);
    logic [7:0] v2, v4, v8;
    v2 = xt(v);
    v4 = xt(v2);
    v8 = xt(v4);
    return (c[0] ? v : 8'h00) ^ (c[1] ? v2 : 8'h00) ^
           (c[2] ? v4 : 8'h00) ^ (c[3] ? v8 : 8'h00);
  endfunction

  logic [0:3][7:0] a, b;

  assign a   = in;
  assign out = b;

  assign b[0] = gm(a[0], 4'he) ^ gm(a[1], 4'hb) ^ gm(a[2], 4'hd) ^ gm(a[3], 4'h9);
  assign b[1] = gm(a[0], 4'h9) ^ gm(a[1], 4'he) ^ gm(a[2], 4'hb) ^ gm(a[3], 4'hd);
  assign b[2] = gm(a[0], 4'hd) ^ gm(a[1], 4'h9) ^ gm(a[2], 4'he) ^ gm(a[3], 4'hb);
  assign b[3] = gm(a[0], 4'hb) ^ gm(a[1], 4'hd) ^ gm(a[2], 4'h9) ^ gm(a[3], 4'he);
endmodule
